cic_decim_ctrl: RTL and testbench

//  Sequencer for the CIC decimation datapath. Generates the low-rate sample strobe (o_clk_low) from a

---
 rtl/cic_pkg.sv | 18 +
 rtl/cic_out_fifo.sv | 91 +++++++++
 rtl/cic_decim_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation sequencer.
//   cic_state_e   : sequencer state encoding (IDLE / FLUSH / RUN)
//   *_DEF         : default parameter values used by cic_decim_ctrl
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } cic_state_e;

  localparam int unsigned RATIO_W_DEF   = 6;
  localparam int unsigned RATIO_RST_DEF = 31;
  localparam int unsigned STAGES_DEF    = 3;
  localparam int unsigned DATA_W_DEF    = 10;
  localparam int unsigned COMB_LAT_DEF  = 1;

endpackage

// File: rtl/cic_out_fifo.sv
// Two-entry registered valid/ready output buffer (no fall-through).
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   push_i, data_i   write request and sample
//   ready_i          consumer ready; pop = valid_o & ready_i
//   clr_overrun_i    clears the sticky overrun flag
//   data_o, valid_o  head of buffer and its valid flag
//   overrun_o        sticky: a push was dropped because the buffer was full
module cic_out_fifo #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  input  logic              clr_overrun_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              pop, full, empty, drop;

  assign pop   = valid_q & ready_i;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

  // Occupancy update; head_q always holds the oldest entry so data_o is a flop
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    drop   = 1'b0;
    unique case ({push_i, pop})
      2'b10: begin
        if (empty) begin
          head_d = data_i;
          cnt_d  = 2'd1;
        end else if (!full) begin
          tail_d = data_i;
          cnt_d  = 2'd2;
        end else begin
          drop = 1'b1;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // pop implies non-empty; occupancy is unchanged
        if (full) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
    valid_d = (cnt_d != 2'd0);
    // a drop in the same cycle as a clear wins
    ovr_d   = drop ? 1'b1 : (clr_overrun_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = head_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimation datapath: low-rate strobe generation,
// comb settling (flush), sample capture and hand-off through a 2-entry buffer.
// Ports:
//   i_clk_high, i_reset        high-rate clock, async active-high reset
//   i_enable                   run request (level)
//   i_ratio_wr, i_ratio        ratio field write (holds R-1; 0 is coerced to 1)
//   o_ratio                    ratio field in use
//   o_clk_low                  one-cycle comb enable strobe, every R cycles
//   i_comb_data                comb output, valid COMB_LAT cycles after o_clk_low
//   o_data, o_valid, i_ready   decimated sample stream
//   o_settled                  high while in RUN
//   o_overrun, i_clr_overrun   sticky dropped-sample flag and its clear
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int unsigned RATIO_W   = RATIO_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned STAGES    = STAGES_DEF,
  parameter int unsigned COMB_LAT  = COMB_LAT_DEF,
  parameter int unsigned RATIO_RST = RATIO_RST_DEF
) (
  input  logic               i_clk_high,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_ratio_wr,
  input  logic [RATIO_W-1:0] i_ratio,
  output logic [RATIO_W-1:0] o_ratio,
  output logic               o_clk_low,
  input  logic [DATA_W-1:0]  i_comb_data,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_settled,
  output logic               o_overrun,
  input  logic               i_clr_overrun
);

  localparam int unsigned FLUSH_W = (STAGES < 2) ? 1 : $clog2(STAGES + 1);

  cic_state_e         state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] shadow_q, shadow_d;
  logic               shadow_vld_q, shadow_vld_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               strobe_q, strobe_d;
  logic               keep_q, keep_d;
  logic [COMB_LAT-1:0] dly_q, dly_d;
  logic               settled_q;
  logic [RATIO_W-1:0] wr_val;
  logic               push_c;

  assign wr_val = (i_ratio == '0) ? RATIO_W'(1) : i_ratio;

  // Next-state: period counter, shadow ratio, flush count and strobe tagging
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ratio_d      = ratio_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    flush_d      = flush_q;
    strobe_d     = 1'b0;
    keep_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // writes (or a shadow left pending on the way into IDLE) apply at once
        if (i_ratio_wr) begin
          ratio_d = wr_val;
        end else if (shadow_vld_q) begin
          ratio_d = shadow_q;
        end
        shadow_vld_d = 1'b0;
        if (i_enable) begin
          state_d = ST_FLUSH;
          flush_d = FLUSH_W'(STAGES);
        end
      end
      ST_FLUSH, ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (i_ratio_wr) begin
            shadow_d     = wr_val;
            shadow_vld_d = 1'b1;
          end
        end else if (cnt_q == ratio_q) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          // only strobes issued while settled produce a kept sample
          keep_d   = (state_q == ST_RUN);
          if (shadow_vld_q) begin
            ratio_d = shadow_q;
            state_d = ST_FLUSH;
            flush_d = FLUSH_W'(STAGES);
          end else if (state_q == ST_FLUSH) begin
            if (flush_q == FLUSH_W'(1)) begin
              state_d = ST_RUN;
            end else begin
              flush_d = flush_q - FLUSH_W'(1);
            end
          end
          // a write landing on the wrap cycle waits for the following wrap
          shadow_vld_d = i_ratio_wr;
          if (i_ratio_wr) begin
            shadow_d = wr_val;
          end
        end else begin
          cnt_d = cnt_q + RATIO_W'(1);
          if (i_ratio_wr) begin
            shadow_d     = wr_val;
            shadow_vld_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Kept strobes travel COMB_LAT cycles; dropping enable flushes the line
  assign dly_d  = i_enable ? COMB_LAT'({dly_q, strobe_q & keep_q}) : '0;
  assign push_c = dly_q[COMB_LAT-1] & i_enable;

  always_ff @(posedge i_clk_high or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ratio_q      <= RATIO_W'(RATIO_RST);
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      flush_q      <= '0;
      strobe_q     <= 1'b0;
      keep_q       <= 1'b0;
      dly_q        <= '0;
      settled_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ratio_q      <= ratio_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      flush_q      <= flush_d;
      strobe_q     <= strobe_d;
      keep_q       <= keep_d;
      dly_q        <= dly_d;
      settled_q    <= (state_d == ST_RUN);
    end
  end

  assign o_ratio   = ratio_q;
  assign o_clk_low = strobe_q;
  assign o_settled = settled_q;

  cic_out_fifo #(
    .DATA_W(DATA_W)
  ) u_out_fifo (
    .clk_i        (i_clk_high),
    .rst_i        (i_reset),
    .push_i       (push_c),
    .data_i       (i_comb_data),
    .ready_i      (i_ready),
    .clr_overrun_i(i_clr_overrun),
    .data_o       (o_data),
    .valid_o      (o_valid),
    .overrun_o    (o_overrun)
  );

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model (period countdown, discard budget, capture due-times, queue).
`timescale 1ns/1ps
module tb_cic_decim_ctrl;

  localparam int unsigned RATIO_W   = 6;
  localparam int unsigned DATA_W    = 10;
  localparam int unsigned STAGES    = 3;
  localparam int unsigned COMB_LAT  = 1;
  localparam int unsigned RATIO_RST = 31;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               wr;
  logic [RATIO_W-1:0] ratio_in;
  logic [RATIO_W-1:0] o_ratio;
  logic               o_clk_low;
  logic [DATA_W-1:0]  comb;
  logic [DATA_W-1:0]  o_data;
  logic               o_valid;
  logic               rdy;
  logic               o_settled;
  logic               o_overrun;
  logic               clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_decim_ctrl #(
    .RATIO_W  (RATIO_W),
    .DATA_W   (DATA_W),
    .STAGES   (STAGES),
    .COMB_LAT (COMB_LAT),
    .RATIO_RST(RATIO_RST)
  ) dut (
    .i_clk_high   (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_ratio_wr   (wr),
    .i_ratio      (ratio_in),
    .o_ratio      (o_ratio),
    .o_clk_low    (o_clk_low),
    .i_comb_data  (comb),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (rdy),
    .o_settled    (o_settled),
    .o_overrun    (o_overrun),
    .i_clr_overrun(clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_cyc = 0;
  bit  m_run, m_settled, m_strobe, m_ovr;
  int  m_ratio, m_pend, m_left, m_disc;
  int  m_cap[$];   // cycle numbers at which a kept sample is taken
  int  m_fifo[$];  // expected buffer contents, oldest first

  task automatic m_reset();
    m_run = 0; m_settled = 0; m_strobe = 0; m_ovr = 0;
    m_ratio = RATIO_RST; m_pend = -1; m_left = 0; m_disc = 0;
    m_cap.delete();
    m_fifo.delete();
  endtask

  initial m_reset();

  always @(posedge clk) begin : model
    int  wv;
    bit  push, pop;
    if (rst) begin
      m_reset();
    end else begin
      wv = (int'(ratio_in) == 0) ? 1 : int'(ratio_in);
      while (m_cap.size() > 0 && m_cap[0] < m_cyc) void'(m_cap.pop_front());
      push = en && m_cap.size() > 0 && m_cap[0] == m_cyc;
      if (push) void'(m_cap.pop_front());
      pop = (m_fifo.size() > 0) && rdy;
      if (pop) void'(m_fifo.pop_front());
      if (push && m_fifo.size() >= 2) m_ovr = 1;
      else begin
        if (push) m_fifo.push_back(int'(comb));
        if (clr) m_ovr = 0;
      end
      m_strobe = 0;
      if (!m_run) begin
        if (wr) m_ratio = wv;
        else if (m_pend >= 0) m_ratio = m_pend;
        m_pend = -1;
        if (en) begin
          m_run = 1; m_left = m_ratio + 1; m_disc = STAGES; m_settled = 0;
        end
      end else if (!en) begin
        m_run = 0; m_settled = 0;
        if (wr) m_pend = wv;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_strobe = 1;
          if (m_settled) m_cap.push_back(m_cyc + 1 + COMB_LAT);
          if (m_pend >= 0) begin
            m_ratio = m_pend; m_disc = STAGES; m_settled = 0;
          end else if (!m_settled) begin
            m_disc--;
            if (m_disc == 0) m_settled = 1;
          end
          m_pend = wr ? wv : -1;
          m_left = m_ratio + 1;
        end else if (wr) begin
          m_pend = wv;
        end
      end
      if (!en) m_cap.delete();
    end
    m_cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("clk_low", int'(o_clk_low), int'(m_strobe));
    chk("ratio",   int'(o_ratio),   m_ratio);
    chk("settled", int'(o_settled), int'(m_settled));
    chk("valid",   int'(o_valid),   int'(m_fifo.size() > 0));
    chk("overrun", int'(o_overrun), int'(m_ovr));
    if (m_fifo.size() > 0) chk("data", int'(o_data), m_fifo[0]);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_clk_low && n < 300);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      comb = DATA_W'($urandom);
    end
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; wr = 1'b0; ratio_in = '0; rdy = 1'b1; clr = 1'b0;
    comb = '0;
    step(2);
    chk("rst_ratio",   int'(o_ratio), 31);
    chk("rst_clk_low", int'(o_clk_low), 0);
    chk("rst_valid",   int'(o_valid), 0);
    chk("rst_settled", int'(o_settled), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    rst = 1'b0;
    step(1);

    // 1: R=32, first strobe 32 cycles after leaving IDLE (33rd negedge from here)
    en = 1'b1;
    wait_strobe(n); chk("t1_first", n, 33);
    wait_strobe(n); chk("t1_period", n, 32);
    wait_strobe(n); chk("t1_third", n, 32);
    chk("t1_settled", int'(o_settled), 1);
    step(2);
    chk("t1_discarded", int'(o_valid), 0);
    wait_strobe(n); chk("t1_fourth", n, 30);
    step(2);
    chk("t1_pushed", int'(o_valid), 1);

    // 2: write 7 at cnt=10; old period completes, then R=8 with fresh flush
    wait_strobe(n); chk("t2_sync", n, 30);
    step(10);
    wr = 1'b1; ratio_in = 6'd7;
    step(1);
    wr = 1'b0;
    wait_strobe(n); chk("t2_old_period", n, 21);
    chk("t2_ratio", int'(o_ratio), 7);
    chk("t2_flush", int'(o_settled), 0);
    wait_strobe(n); chk("t2_new_period", n, 8);
    wait_strobe(n); chk("t2_new_period2", n, 8);
    wait_strobe(n); chk("t2_new_period3", n, 8);
    chk("t2_settled", int'(o_settled), 1);

    // 3: ratio 0 written in IDLE is coerced to 1 -> strobe every 2 cycles
    en = 1'b0;
    step(2);
    wr = 1'b1; ratio_in = '0;
    step(1);
    wr = 1'b0;
    chk("t3_ratio", int'(o_ratio), 1);
    en = 1'b1;
    wait_strobe(n); chk("t3_first", n, 3);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(n); chk("t3_period", n, 2);
    end

    // 4: consumer stalls, buffer fills and overruns
    rdy = 1'b0;
    step(20);
    chk("t4_overrun", int'(o_overrun), 1);
    chk("t4_valid", int'(o_valid), 1);

    // 5: push and pop together while full, with overrun clear
    wait_strobe(n); chk("t5_strobe_seen", int'(o_clk_low), 1);
    step(1);
    rdy = 1'b1; clr = 1'b1;
    step(1);
    rdy = 1'b0; clr = 1'b0;
    chk("t5_no_overrun", int'(o_overrun), 0);
    chk("t5_still_valid", int'(o_valid), 1);
    step(2);
    rdy = 1'b1;
    step(10);

    // 6: enable drop with a kept strobe in flight, then async reset mid-period
    wait_strobe(n); chk("t6_strobe_seen", int'(o_clk_low), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t6_no_push", int'(o_valid), 0);
    end
    chk("t6_idle_settled", int'(o_settled), 0);
    chk("t6_idle_strobe", int'(o_clk_low), 0);
    en = 1'b1; wr = 1'b1; ratio_in = 6'd20;
    step(1);
    wr = 1'b0;
    step(14);
    chk("t6_pre_ratio", int'(o_ratio), 20);
    chk("t6_pre_overrun", int'(o_overrun), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_ratio",   int'(o_ratio), 31);
    chk("t6_async_clk_low", int'(o_clk_low), 0);
    chk("t6_async_valid",   int'(o_valid), 0);
    chk("t6_async_settled", int'(o_settled), 0);
    chk("t6_async_overrun", int'(o_overrun), 0);
    chk("t6_async_data",    int'(o_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      en  = ($urandom_range(0, 99) != 0);
      wr  = ($urandom_range(0, 49) == 0);
      ratio_in = ($urandom_range(0, 9) == 0) ? RATIO_W'($urandom) :
                                               RATIO_W'($urandom_range(0, 6));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; wr = 1'b0; clr = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
